// File: rtl/fg_multimode_wavegen_if.sv
// ---------------------------------------------------------------------------
// fg_multimode_wavegen_if
//   Bundles the timebase, configuration and sample signals of the
//   multimode waveform generator. Clock and reset stay plain module ports.
//
//   master modport : driver side (timebase source / register block)
//   slave modport  : the generator itself
//
//   Signals
//     strb_data_valid_i  timebase tick
//     counterValue_i     current timebase count
//     cfg_load_i         one-cycle pulse capturing the cfg inputs
//     mode_i .. offset_i configuration values
//     out_o              registered sample
//     strb_data_valid_o  strobe delayed by one clock
//     period_start_o     sample came from counterValue_i == 0
//     cfg_pending_o      captured cfg waiting for the next period start
// ---------------------------------------------------------------------------
interface fg_multimode_wavegen_if #(
    parameter int COUNTER_BITWIDTH  = 32,
    parameter int WAVEFORM_BITWIDTH = 16
);
    logic                         strb_data_valid_i;
    logic [COUNTER_BITWIDTH-1:0]  counterValue_i;
    logic                         cfg_load_i;
    logic [1:0]                   mode_i;
    logic [COUNTER_BITWIDTH-1:0]  counter_i;
    logic [COUNTER_BITWIDTH-1:0]  ON_counter_i;
    logic [WAVEFORM_BITWIDTH-1:0] k_rise_i;
    logic [WAVEFORM_BITWIDTH-1:0] k_fall_i;
    logic [WAVEFORM_BITWIDTH-1:0] amplitude_i;
    logic [WAVEFORM_BITWIDTH-1:0] offset_i;
    logic [WAVEFORM_BITWIDTH-1:0] out_o;
    logic                         strb_data_valid_o;
    logic                         period_start_o;
    logic                         cfg_pending_o;

    modport master (
        output strb_data_valid_i, counterValue_i, cfg_load_i, mode_i,
               counter_i, ON_counter_i, k_rise_i, k_fall_i, amplitude_i,
               offset_i,
        input  out_o, strb_data_valid_o, period_start_o, cfg_pending_o
    );

    modport slave (
        input  strb_data_valid_i, counterValue_i, cfg_load_i, mode_i,
               counter_i, ON_counter_i, k_rise_i, k_fall_i, amplitude_i,
               offset_i,
        output out_o, strb_data_valid_o, period_start_o, cfg_pending_o
    );
endinterface

// File: rtl/fg_multimode_wavegen.sv
// ---------------------------------------------------------------------------
// fg_multimode_wavegen
//   Produces one unsigned sample per timebase strobe in TRAPEZOID, SQUARE,
//   SAWTOOTH or DC mode, adds a saturating DC offset and registers the
//   result. Configuration is double-buffered: cfg_load_i captures into a
//   pending set which becomes active only on a strobe with count == 0.
//
//   Ports
//     clk_i   rising-edge clock
//     rstn_i  asynchronous active-low reset
//     bus     fg_multimode_wavegen_if.slave (timebase, cfg, sample outputs);
//             its widths must match COUNTER_BITWIDTH / WAVEFORM_BITWIDTH
// ---------------------------------------------------------------------------
module fg_multimode_wavegen #(
    parameter int COUNTER_BITWIDTH  = 32,
    parameter int WAVEFORM_BITWIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    fg_multimode_wavegen_if.slave  bus
);
    localparam int CW = COUNTER_BITWIDTH;
    localparam int WW = WAVEFORM_BITWIDTH;

    typedef enum logic [1:0] {
        MODE_TRAPEZOID = 2'd0,
        MODE_SQUARE    = 2'd1,
        MODE_SAWTOOTH  = 2'd2,
        MODE_DC        = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_ON   = 2'd2,
        S_FALL = 2'd3
    } state_e;

    typedef struct packed {
        mode_e          mode;
        logic [CW-1:0]  counter;
        logic [CW-1:0]  on_counter;
        logic [WW-1:0]  k_rise;
        logic [WW-1:0]  k_fall;
        logic [WW-1:0]  amp;
        logic [WW-1:0]  offset;
    } cfg_t;

    cfg_t           active_q, pending_q, pending_d, cfg;
    logic           pending_flag_q;
    state_e         state_q, state_d, cur_state;
    logic [WW-1:0]  val_q, val_d, cur_val;
    logic [WW-1:0]  out_q, out_d;
    logic           strb_q, period_start_q;

    logic           period_start, apply, mode_change;
    logic [CW-1:0]  cnt;
    logic [WW:0]    rise_sum, out_sum;
    logic [WW-1:0]  rise_val, fall_val, saw_start;

    assign cnt = bus.counterValue_i;

    always_comb begin
        pending_d = '{
            mode:       mode_e'(bus.mode_i),
            counter:    bus.counter_i,
            on_counter: bus.ON_counter_i,
            k_rise:     bus.k_rise_i,
            k_fall:     bus.k_fall_i,
            amp:        bus.amplitude_i,
            offset:     bus.offset_i
        };
    end

    // A load in the same clock as a period start wins: the fresh values are
    // captured and the apply waits for the next period start.
    assign period_start = bus.strb_data_valid_i && (cnt == '0);
    assign apply        = period_start && pending_flag_q && !bus.cfg_load_i;
    assign cfg          = apply ? pending_q : active_q;
    assign mode_change  = apply && (pending_q.mode != active_q.mode);

    // A mode change restarts the waveform from its entry point with val = 0.
    assign cur_state = mode_change ? S_IDLE : state_q;
    assign cur_val   = mode_change ? '0 : val_q;

    // Rising step clamps at amp and on carry-out; falling step clamps at 0.
    assign rise_sum  = {1'b0, cur_val} + {1'b0, cfg.k_rise};
    assign rise_val  = (rise_sum[WW] || (rise_sum[WW-1:0] > cfg.amp))
                       ? cfg.amp : rise_sum[WW-1:0];
    assign fall_val  = (cfg.k_fall > cur_val) ? '0 : (cur_val - cfg.k_fall);
    assign saw_start = (cfg.k_rise > cfg.amp) ? cfg.amp : cfg.k_rise;

    // NOTE: every variable written in this block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = cur_state;
        val_d   = cur_val;
        unique case (cfg.mode)
            MODE_TRAPEZOID: begin
                unique case (cur_state)
                    S_IDLE: if (cnt == '0) state_d = S_RISE;
                    S_RISE: begin
                        if (cnt == cfg.on_counter)   state_d = S_FALL;
                        else if (cur_val == cfg.amp) state_d = S_ON;
                        else if (cnt == cfg.counter) state_d = S_IDLE;
                    end
                    S_ON: begin
                        if (cnt == '0)                  state_d = S_RISE;
                        else if (cnt == cfg.on_counter) state_d = S_FALL;
                    end
                    S_FALL: begin
                        if (cnt == '0)          state_d = S_RISE;
                        else if (cur_val == '0) state_d = S_IDLE;
                    end
                endcase
                unique case (state_d)
                    S_IDLE: val_d = '0;
                    S_RISE: val_d = rise_val;
                    S_ON:   val_d = cfg.amp;
                    S_FALL: val_d = fall_val;
                endcase
            end
            MODE_SQUARE: begin
                if (cnt < cfg.on_counter) begin
                    state_d = S_ON;
                    val_d   = cfg.amp;
                end else begin
                    state_d = S_IDLE;
                    val_d   = '0;
                end
            end
            MODE_SAWTOOTH: begin
                if (cnt == '0) begin
                    state_d = S_RISE;
                    val_d   = saw_start;
                end else if (cur_state == S_RISE) begin
                    val_d   = rise_val;
                end else begin
                    state_d = S_IDLE;
                    val_d   = '0;
                end
            end
            MODE_DC: begin
                state_d = S_ON;
                val_d   = cfg.amp;
            end
        endcase
    end

    assign out_sum = {1'b0, val_d} + {1'b0, cfg.offset};
    assign out_d   = out_sum[WW] ? '1 : out_sum[WW-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q        <= S_IDLE;
            val_q          <= '0;
            out_q          <= '0;
            strb_q         <= 1'b0;
            period_start_q <= 1'b0;
            pending_flag_q <= 1'b0;
            active_q       <= '0;
            pending_q      <= '0;
        end else begin
            strb_q         <= bus.strb_data_valid_i;
            period_start_q <= period_start;

            if (bus.cfg_load_i) begin
                pending_q      <= pending_d;
                pending_flag_q <= 1'b1;
            end else if (apply) begin
                pending_flag_q <= 1'b0;
            end

            if (apply) active_q <= pending_q;

            if (bus.strb_data_valid_i) begin
                state_q <= state_d;
                val_q   <= val_d;
                out_q   <= out_d;
            end
        end
    end

    assign bus.out_o             = out_q;
    assign bus.strb_data_valid_o = strb_q;
    assign bus.period_start_o    = period_start_q;
    assign bus.cfg_pending_o     = pending_flag_q;

endmodule

// File: tb/tb_fg_multimode_wavegen.sv
// ---------------------------------------------------------------------------
// tb_fg_multimode_wavegen
//   Directed, table-driven bench for fg_multimode_wavegen. Each vector picks
//   a configuration record, drives strobe / count / load for one clock and
//   compares out_o, strb_data_valid_o, period_start_o and cfg_pending_o
//   against hand-computed values. Reset sequences are written out by hand.
// ---------------------------------------------------------------------------
module tb_fg_multimode_wavegen;
    localparam int CW = 32;
    localparam int WW = 16;

    typedef struct {
        logic [1:0]    mode;
        logic [CW-1:0] counter;
        logic [CW-1:0] on_counter;
        logic [WW-1:0] k_rise;
        logic [WW-1:0] k_fall;
        logic [WW-1:0] amp;
        logic [WW-1:0] offset;
    } cfg_t;

    typedef struct {
        int            cfg_sel;
        logic          strb;
        logic          load;
        logic [CW-1:0] cnt;
        logic [WW-1:0] exp_out;
        logic          exp_sv;
        logic          exp_ps;
        logic          exp_pend;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    cfg_t cfgs[9];
    vec_t vecs[$];

    fg_multimode_wavegen_if #(.COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(WW)) bus ();

    fg_multimode_wavegen #(.COUNTER_BITWIDTH(CW), .WAVEFORM_BITWIDTH(WW)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int sel, input logic strb, input logic load,
                                input int cnt, input int out, input logic pend);
        vec_t v;
        v.cfg_sel  = sel;
        v.strb     = strb;
        v.load     = load;
        v.cnt      = CW'(cnt);
        v.exp_out  = WW'(out);
        v.exp_sv   = strb;
        v.exp_ps   = strb && (cnt == 0);
        v.exp_pend = pend;
        return v;
    endfunction

    // Drives one vector just after a rising edge, lets the next edge consume
    // it and samples the outputs 1 ns later.
    task automatic apply_vec(input vec_t v, input string tag);
        bus.mode_i            = cfgs[v.cfg_sel].mode;
        bus.counter_i         = cfgs[v.cfg_sel].counter;
        bus.ON_counter_i      = cfgs[v.cfg_sel].on_counter;
        bus.k_rise_i          = cfgs[v.cfg_sel].k_rise;
        bus.k_fall_i          = cfgs[v.cfg_sel].k_fall;
        bus.amplitude_i       = cfgs[v.cfg_sel].amp;
        bus.offset_i          = cfgs[v.cfg_sel].offset;
        bus.strb_data_valid_i = v.strb;
        bus.counterValue_i    = v.cnt;
        bus.cfg_load_i        = v.load;
        @(posedge clk);
        #1;
        check({tag, " out"},     32'(bus.out_o),             32'(v.exp_out));
        check({tag, " strb_o"},  32'(bus.strb_data_valid_o), 32'(v.exp_sv));
        check({tag, " pstart"},  32'(bus.period_start_o),    32'(v.exp_ps));
        check({tag, " pending"}, 32'(bus.cfg_pending_o),     32'(v.exp_pend));
        bus.cfg_load_i = 1'b0;
    endtask

    function automatic int trap_exp(input int c);
        // counter=19, ON=10, k=100, amp=300 starting from IDLE at c == 0
        if (c == 0)  return 100;
        if (c == 1)  return 200;
        if (c <= 9)  return 300;
        if (c == 10) return 200;
        if (c == 11) return 100;
        return 0;
    endfunction

    initial begin
        //          mode   counter  on      k_rise     k_fall   amp        offset
        cfgs[0] = '{2'd0, 32'd19,  32'd10, 16'd100,   16'd100, 16'd300,   16'd0};
        cfgs[1] = '{2'd1, 32'd9,   32'd5,  16'd0,     16'd0,   16'hFFFF,  16'd10};
        cfgs[2] = '{2'd2, 32'd9,   32'd5,  16'h7000,  16'd0,   16'hF000,  16'd0};
        cfgs[3] = '{2'd1, 32'd9,   32'd5,  16'd0,     16'd0,   16'd1000,  16'd0};
        cfgs[4] = '{2'd3, 32'd9,   32'd5,  16'd0,     16'd0,   16'd500,   16'd0};
        cfgs[5] = '{2'd3, 32'd9,   32'd5,  16'd0,     16'd0,   16'd700,   16'd0};
        cfgs[6] = '{2'd3, 32'd9,   32'd5,  16'd0,     16'd0,   16'd800,   16'd0};
        cfgs[7] = '{2'd3, 32'd9,   32'd5,  16'd0,     16'd0,   16'hFF00,  16'h0200};
        cfgs[8] = '{2'd0, 32'd0,   32'd5,  16'd50,    16'd50,  16'd300,   16'd0};

        // Trapezoid from IDLE, with one idle clock (no strobe) inside ON.
        vecs.push_back(mk(0, 0, 1, 7, 0, 1));
        for (int c = 0; c < 20; c++) begin
            vecs.push_back(mk(0, 1, 0, c, trap_exp(c), 0));
            if (c == 5) vecs.push_back(mk(0, 0, 0, 6, 300, 0));
        end
        for (int c = 0; c < 3; c++) vecs.push_back(mk(0, 1, 0, c, trap_exp(c), 0));

        // Square with offset saturating the high level, two periods.
        vecs.push_back(mk(1, 0, 1, 3, 300, 1));
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 10; c++)
                vecs.push_back(mk(1, 1, 0, c, (c < 5) ? 16'hFFFF : 10, 0));

        // Sawtooth: 0xE000 + 0x7000 carries out and must clamp to amp.
        vecs.push_back(mk(2, 0, 1, 0, 10, 1));
        for (int c = 0; c < 12; c++) begin
            int cc;
            cc = c % 10;
            vecs.push_back(mk(2, 1, 0, cc,
                (cc == 0) ? 16'h7000 : (cc == 1) ? 16'hE000 : 16'hF000, 0));
        end

        // Square 1000, then mid-period load of DC 500.
        vecs.push_back(mk(3, 0, 1, 0, 16'hE000, 1));
        for (int c = 0; c < 4; c++) vecs.push_back(mk(3, 1, 0, c, 1000, 0));
        vecs.push_back(mk(4, 0, 1, 0, 1000, 1));
        vecs.push_back(mk(4, 1, 0, 4, 1000, 1));
        for (int c = 5; c < 10; c++) vecs.push_back(mk(4, 1, 0, c, 0, 1));
        vecs.push_back(mk(4, 1, 0, 0, 500, 0));
        vecs.push_back(mk(4, 1, 0, 1, 500, 0));

        // Load coinciding with cnt == 0 defers the apply by one period.
        vecs.push_back(mk(5, 0, 1, 0, 500, 1));
        for (int c = 2; c < 10; c++) vecs.push_back(mk(5, 1, 0, c, 500, 1));
        vecs.push_back(mk(6, 1, 1, 0, 500, 1));
        for (int c = 1; c < 10; c++) vecs.push_back(mk(6, 1, 0, c, 500, 1));
        vecs.push_back(mk(6, 1, 0, 0, 800, 0));

        // DC + offset saturating to all-ones.
        vecs.push_back(mk(7, 0, 1, 0, 800, 1));
        vecs.push_back(mk(7, 1, 0, 0, 16'hFFFF, 0));
        vecs.push_back(mk(7, 1, 0, 1, 16'hFFFF, 0));

        // counter == 0: every strobe is a period start, alternating k_rise / 0.
        vecs.push_back(mk(8, 0, 1, 0, 16'hFFFF, 1));
        vecs.push_back(mk(8, 1, 0, 0, 50, 0));
        vecs.push_back(mk(8, 1, 0, 0, 0, 0));
        vecs.push_back(mk(8, 1, 0, 0, 50, 0));
        vecs.push_back(mk(8, 1, 0, 0, 0, 0));

        // Back to the reference trapezoid, stopping in FALL at cnt == 11.
        vecs.push_back(mk(0, 0, 1, 0, 0, 1));
        for (int c = 0; c < 12; c++) vecs.push_back(mk(0, 1, 0, c, trap_exp(c), 0));

        // ---- reset state ----
        bus.strb_data_valid_i = 1'b0;
        bus.counterValue_i    = '0;
        bus.cfg_load_i        = 1'b0;
        bus.mode_i            = '0;
        bus.counter_i         = '0;
        bus.ON_counter_i      = '0;
        bus.k_rise_i          = '0;
        bus.k_fall_i          = '0;
        bus.amplitude_i       = '0;
        bus.offset_i          = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out",     32'(bus.out_o),             32'd0);
        check("reset strb_o",  32'(bus.strb_data_valid_o), 32'd0);
        check("reset pstart",  32'(bus.period_start_o),    32'd0);
        check("reset pending", 32'(bus.cfg_pending_o),     32'd0);
        rstn = 1'b1;

        // ---- table ----
        foreach (vecs[i]) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // ---- asynchronous reset mid-FALL, between clock edges ----
        #3;
        rstn = 1'b0;
        #1;
        check("async rst out",     32'(bus.out_o),             32'd0);
        check("async rst strb_o",  32'(bus.strb_data_valid_o), 32'd0);
        check("async rst pstart",  32'(bus.period_start_o),    32'd0);
        check("async rst pending", 32'(bus.cfg_pending_o),     32'd0);
        @(posedge clk);
        #1;
        check("held rst out",    32'(bus.out_o),             32'd0);
        check("held rst strb_o", 32'(bus.strb_data_valid_o), 32'd0);
        rstn = 1'b1;

        // After release with cnt != 0 the output stays 0 until cnt == 0.
        apply_vec(mk(0, 1, 1, 12, 0, 1), "post rst load");
        for (int c = 13; c < 20; c++)
            apply_vec(mk(0, 1, 0, c, 0, 1), $sformatf("post rst cnt%0d", c));
        apply_vec(mk(0, 1, 0, 0, 100, 0), "post rst start");
        apply_vec(mk(0, 1, 0, 1, 200, 0), "post rst cnt1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
